// File: rtl/mem_stall_controller.sv
// MEM-stage sequencer for a variable-latency data memory: holds the pipeline
// while a req/ready access is outstanding and traps a hung memory in a sticky error.
module mem_stall_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemReady,
  input  logic [31:0] MemRdata,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [31:0] MemReadDataM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushW,
  output logic        MemErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             stall;

  assign access = MemReadM | MemWriteM;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      MemReq       <= 1'b0;
      MemWe        <= 1'b0;
      MemErr       <= 1'b0;
      MemAddr      <= '0;
      MemWdata     <= '0;
      MemReadDataM <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state    <= REQ;
            MemReq   <= 1'b1;
            MemAddr  <= ALUResultM;
            MemWdata <= WriteDataM;
            // A simultaneous read+write is carried out as a write.
            MemWe    <= MemWriteM;
            cnt      <= '0;
          end
        end
        REQ: begin
          if (MemReady) begin
            state  <= DONE;
            MemReq <= 1'b0;
            if (!MemWe) MemReadDataM <= MemRdata;
          end else if (cnt == CntLast) begin
            state  <= ERR;
            MemReq <= 1'b0;
            MemErr <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: state <= IDLE;
        ERR:  state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Pipeline hold is released only in DONE (and never asserted under reset).
  always_comb begin
    stall = 1'b0;
    if (Rst_n) begin
      stall = ((state == IDLE) && access) || (state == REQ) || (state == ERR);
    end
  end

  assign StallF = stall;
  assign StallD = stall;
  assign StallE = stall;
  assign StallM = stall;
  assign FlushW = stall;

endmodule

// File: doc/mem_stall_controller.md
Name: mem_stall_controller

Overview:
- Sequences the data-memory access of the MEM stage when data memory has variable latency (req/ready handshake).
- Freezes IF/ID/EX/MEM pipeline registers and injects a bubble into the MEM/WB register until the access completes.
- Latches the read data so the MEM/WB register captures it when the pipeline advances.
- Includes a timeout watchdog that freezes the pipeline and flags an error on a hung memory.

Parameters:
- TIMEOUT, 16: max REQ cycles without MemReady before entering ERR (legal range 2..255).
- CNT_W, 8: width of the wait counter (must hold TIMEOUT-1).

Ports:
- Clk  input  1  pipeline clock, all state on posedge.
- Rst_n  input  1  asynchronous active-low reset.
- MemReadM  input  1  load in MEM stage (from EX/MEM register).
- MemWriteM  input  1  store in MEM stage.
- ALUResultM  input  32  byte address of access.
- WriteDataM  input  32  store data.
- MemReady  input  1  memory completion, sampled only in REQ.
- MemRdata  input  32  memory read data, valid when MemReady=1.
- MemReq  output  1  access request to memory.
- MemWe  output  1  write enable, qualified by MemReq.
- MemAddr  output  32  registered address.
- MemWdata  output  32  registered store data.
- MemReadDataM  output  32  latched load data, feeds the MEM/WB register.
- StallF, StallD, StallE, StallM  output  1 each  hold the corresponding pipeline register.
- FlushW  output  1  clears RegWriteW/MemtoRegW/jalW in the MEM/WB register (bubble).
- MemErr  output  1  sticky timeout error.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE, cnt=0; MemReq, MemWe, MemErr=0; MemAddr, MemWdata, MemReadDataM=0. All stalls and FlushW are forced to 0 while Rst_n=0.
- Reset mid-access: abandons the access immediately. MemReq drops asynchronously. The memory side must tolerate a dropped request.
- access = MemReadM | MemWriteM. If both are set, treat the access as a write: MemWe=1, MemReadDataM unchanged.
- State IDLE:
  - If access=1, go to REQ. On the same edge, latch MemAddr<=ALUResultM, MemWdata<=WriteDataM, MemWe<=MemWriteM, and clear cnt.
  - Otherwise stay in IDLE.
- State REQ:
  - MemReq=1 (registered, Moore output).
  - Hold MemReq and all Mem* outputs stable until MemReady=1 is sampled.
  - MemReady=1: go to DONE. If the access is a read, MemReadDataM<=MemRdata.
  - MemReady=0 and cnt==TIMEOUT-1: go to ERR.
  - Otherwise cnt<=cnt+1.
- State DONE:
  - MemReq=0; stalls and FlushW low for exactly 1 cycle, so the pipeline advances and MEM/WB captures MemReadDataM.
  - Next state IDLE unconditionally.
- State ERR: MemReq=0, MemErr=1; stalls and FlushW held at 1 until reset. This state is terminal.
- Stall/flush (combinational):
  - Stall = (IDLE & access) | REQ | ERR.
  - StallF=StallD=StallE=StallM=Stall; FlushW=Stall.
- Timing:
  - Access detected in cycle 0; REQ begins in cycle 1.
  - If MemReady arrives in the k-th REQ cycle (k≥1), DONE occurs in cycle k+1 and the pipeline advances on the edge ending that cycle.
  - Minimum stall = 2 cycles (k=1).
- MemReady is ignored in IDLE, DONE and ERR.
- Back-to-back accesses: the next instruction enters MEM at the end of DONE, is seen in IDLE the following cycle, and starts its own stall. There is no overlap.
- Non-memory instructions incur zero stall cycles.
- MemReadDataM holds its last loaded value between loads.

Test Plan:
- Reset check: Rst_n low for 3 cycles with MemReadM=1 -> all outputs 0. After release, a 2-cycle stall starts from IDLE.
- Load, 1-cycle memory: MemReadM=1, ALUResultM=0x100; MemReady=1 in the first REQ cycle with MemRdata=0xDEADBEEF.
  -> MemReq high 1 cycle, MemAddr=0x100, MemWe=0.
  -> Stall/FlushW high cycles 0-1, DONE in cycle 2, MemReadDataM=0xDEADBEEF.
- Store, 4-cycle memory: MemWriteM=1, WriteDataM=0x12345678; MemReady asserted on the 4th REQ cycle.
  -> MemWe=1 and MemReq held 4 cycles with stable addr/data.
  -> Stall high 5 cycles; MemReadDataM unchanged.
- Back-to-back loads: two consecutive lw with 1-cycle memory -> stall pattern 1,1,0,1,1,0. Two distinct data values are captured in order.
- Timeout: MemReadM=1 with MemReady never asserted, TIMEOUT=16 -> after 16 REQ cycles, ERR is entered: MemErr=1, MemReq=0, stalls stuck at 1. Later MemReady pulses are ignored; only Rst_n clears the error.
- Reset mid-REQ: Rst_n pulsed low in the 3rd REQ cycle -> MemReq drops immediately, state returns to IDLE, counter clears, MemErr stays 0.
